dpll_phase_ctrl: RTL

- Phase detector and loop-filter front end of the digital PLL.
- Recovers phase from an asynchronous serial input `data_in` against the DCO output `pwm_clk`. Generates the DCO control pulses `add` (lengthen period), `plus` (shorten period) and `bothedge` (restart DCO period).
- Sits between the line input and the DCO. All three outputs connect directly to the DCO inputs of the same names.
- Same `clk` domain as the DCO.

---
 rtl/dpll_pkg.sv | 22 ++
 rtl/dpll_edge_sync.sv | 55 +++++
 rtl/dpll_phase_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// Shared types and constants for the DPLL phase front end.
// Used by dpll_phase_ctrl, dpll_edge_sync and the DCO integration top.
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } dpll_state_e;

    // Phase vote: DCO early lengthens, DCO late shortens
    localparam logic signed [1:0] VOTE_EARLY = 2'sd1;
    localparam logic signed [1:0] VOTE_LATE  = -2'sd1;

    localparam int DPLL_LF_K      = 4;
    localparam int DPLL_ACQ_EDGES = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/dpll_edge_sync.sv
// Synchronizes data_in and flags both transition polarities.
// DPLL_PHASE_DEGLITCH_EN adds a 3-tap majority filter (+2 cycles).
module dpll_edge_sync
    import dpll_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic data_in,
    output logic data_edge
);

    logic s1;
    logic s2;
    logic s3;
    logic hist_in;

`ifdef DPLL_PHASE_DEGLITCH_EN
    logic d1;
    logic d2;
    logic filt;

    // Majority of three s2 samples, registered, drops 1-cycle glitches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1   <= 1'b0;
            d2   <= 1'b0;
            filt <= 1'b0;
        end else begin
            d1   <= s2;
            d2   <= d1;
            filt <= maj3(s2, d1, d2);
        end
    end

    assign hist_in = filt;
`else
    assign hist_in = s2;
`endif

    // Two-flop synchronizer plus history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= data_in;
            s2 <= s1;
            s3 <= hist_in;
        end
    end

    assign data_edge = hist_in ^ s3;

endmodule

// File: rtl/dpll_phase_ctrl.sv
// DPLL phase detector and loop filter driving the DCO add/plus/bothedge.
// Optional input deglitch: define DPLL_PHASE_DEGLITCH_EN.
module dpll_phase_ctrl
    import dpll_pkg::*;
#(
    parameter int ACQ_EDGES  = DPLL_ACQ_EDGES,
    parameter int LF_K       = DPLL_LF_K,
    parameter int LF_W       = 8,
    parameter int LOS_CYCLES = 1024,
    parameter int TO_W       = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic data_in,
    input  logic pwm_clk,
    output logic add,
    output logic plus,
    output logic bothedge,
    output logic locked
);

    localparam int CW = $clog2(ACQ_EDGES + 1);
    localparam logic signed [LF_W-1:0] K_POS = LF_W'(LF_K);
    localparam logic signed [LF_W-1:0] K_NEG = -K_POS;
    localparam logic [TO_W-1:0] LOS_MAX = TO_W'(LOS_CYCLES);
    localparam logic [TO_W-1:0] LOS_PRE = TO_W'(LOS_CYCLES - 1);

    dpll_state_e            state;
    logic signed [LF_W-1:0] acc;
    logic [CW-1:0]          edge_cnt;
    logic [TO_W-1:0]        los_cnt;

    logic                   data_edge;
    logic signed [LF_W-1:0] vote;
    logic signed [LF_W-1:0] acc_sum;
    logic [CW-1:0]          cnt_inc;
    logic                   los_hit;

    dpll_edge_sync u_edge_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .data_edge (data_edge)
    );

    // Vote, next accumulator value and loss-of-signal detection
    always_comb begin
        vote    = LF_W'(pwm_clk ? VOTE_EARLY : VOTE_LATE);
        acc_sum = acc + vote;
        cnt_inc = edge_cnt + CW'(1);
        los_hit = !data_edge && (los_cnt == LOS_PRE);
    end

    // Acquire/track FSM, loop filter and registered DCO pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            acc      <= '0;
            edge_cnt <= '0;
            los_cnt  <= '0;
            add      <= 1'b0;
            plus     <= 1'b0;
            bothedge <= 1'b0;
            locked   <= 1'b0;
        end else begin
            add      <= 1'b0;
            plus     <= 1'b0;
            bothedge <= 1'b0;

            if (data_edge)
                los_cnt <= '0;
            else if (los_cnt != LOS_MAX)
                los_cnt <= los_cnt + TO_W'(1);

            if (los_hit) begin
                state    <= IDLE;
                acc      <= '0;
                edge_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                locked <= (state == TRACK);
                unique case (state)
                    IDLE: begin
                        if (data_edge) begin
                            bothedge <= 1'b1;
                            edge_cnt <= CW'(1);
                            acc      <= '0;
                            state    <= (ACQ_EDGES == 1) ? TRACK : ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        acc <= '0;
                        if (data_edge) begin
                            bothedge <= 1'b1;
                            edge_cnt <= cnt_inc;
                            if (cnt_inc == CW'(ACQ_EDGES))
                                state <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (data_edge) begin
                            if (acc_sum == K_POS) begin
                                add <= 1'b1;
                                acc <= '0;
                            end else if (acc_sum == K_NEG) begin
                                plus <= 1'b1;
                                acc  <= '0;
                            end else begin
                                acc <= acc_sum;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
